sw_max_argmax_tree: RTL and testbench

//  Pipelined NUM_IN-lane max-reduction tree with frame accumulator for the Smith-Waterman score path.

---
 rtl/sw_max_argmax_tree_pkg.sv | 15 +
 rtl/sw_max_argmax_tree_node.sv | 34 +++
 rtl/sw_max_argmax_tree.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sw_max_argmax_tree.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_max_argmax_tree_pkg.sv
// Shared defaults and accumulator state type for sw_max_argmax_tree.
// Index logic is built only with SW_MAX_ARGMAX_EN defined.
package sw_max_argmax_tree_pkg;

  localparam int SW_V_E_F_BIT      = 17;
  localparam int SW_PE_ARRAY_SIZE  = 64;
  localparam int SW_MAX_T_BIT      = 13;
  localparam int SW_MAX_PIPE_EVERY = 2;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sw_max_argmax_tree_node.sv
// Combinational 2-input {value, idx} max: negatives clamp to 0, a wins ties.
// Index ports exist only with SW_MAX_ARGMAX_EN defined.
module sw_max_node
  import sw_max_argmax_tree_pkg::*;
#(
  parameter int DW = SW_V_E_F_BIT
`ifdef SW_MAX_ARGMAX_EN
  , parameter int IW = SW_MAX_T_BIT
`endif
) (
  input  logic [DW-1:0] i_a_val,
  input  logic [DW-1:0] i_b_val,
`ifdef SW_MAX_ARGMAX_EN
  input  logic [IW-1:0] i_a_idx,
  input  logic [IW-1:0] i_b_idx,
  output logic [IW-1:0] o_idx,
`endif
  output logic [DW-1:0] o_val
);

  logic [DW-2:0] w_a_mag;
  logic [DW-2:0] w_b_mag;
  logic          w_b_win;

  assign w_a_mag = i_a_val[DW-1] ? '0 : i_a_val[DW-2:0];
  assign w_b_mag = i_b_val[DW-1] ? '0 : i_b_val[DW-2:0];
  assign w_b_win = w_b_mag > w_a_mag;
  assign o_val   = {1'b0, (w_b_win ? w_b_mag : w_a_mag)};

`ifdef SW_MAX_ARGMAX_EN
  assign o_idx = w_b_win ? i_b_idx : i_a_idx;
`endif

endmodule

// File: rtl/sw_max_argmax_tree.sv
// Pipelined NUM_IN-lane max/argmax tree with frame accumulator.
// Define SW_MAX_ARGMAX_EN to build the column index path.
module sw_max_argmax_tree
  import sw_max_argmax_tree_pkg::*;
#(
  parameter int DATA_WIDTH = SW_V_E_F_BIT,
  parameter int NUM_IN     = SW_PE_ARRAY_SIZE,
  parameter int IDX_WIDTH  = SW_MAX_T_BIT,
  parameter int PIPE_EVERY = SW_MAX_PIPE_EVERY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_max,
  output logic [IDX_WIDTH-1:0]         out_idx,
  output logic                         ovf_err
);

  localparam int LEVELS = $clog2(NUM_IN);

  logic                  w_in_vld;
  logic                  w_t_vld;
  logic                  w_t_lst;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_t_val;
  logic [DATA_WIDTH-1:0] w_m_val;
  logic [DATA_WIDTH-1:0] w_res_val;
  logic                  w_wrap_err;

  acc_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_acc_val;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_max;
  logic                  r_ovf;

  assign w_in_vld = in_valid & ~flush;

`ifdef SW_MAX_ARGMAX_EN
  localparam int BW = IDX_WIDTH - LEVELS;

  logic [BW-1:0]        r_beat;
  logic                 r_wrap;
  logic [IDX_WIDTH-1:0] w_t_idx;
  logic [IDX_WIDTH-1:0] w_m_idx;
  logic [IDX_WIDTH-1:0] w_res_idx;
  logic [IDX_WIDTH-1:0] r_acc_idx;
  logic [IDX_WIDTH-1:0] r_out_idx;

  // r_wrap marks a frame whose beat index has rolled past 2^IDX_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_wrap <= 1'b0;
    end else if (flush) begin
      r_beat <= '0;
      r_wrap <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        r_beat <= '0;
        r_wrap <= 1'b0;
      end else begin
        r_beat <= r_beat + 1'b1;
        if (&r_beat) r_wrap <= 1'b1;
      end
    end
  end

  assign w_wrap_err = w_in_vld & r_wrap;
`else
  assign w_wrap_err = 1'b0;
`endif

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lv
    localparam int N = NUM_IN >> l;
    logic [DATA_WIDTH-1:0] w_val [N];
`ifdef SW_MAX_ARGMAX_EN
    logic [IDX_WIDTH-1:0]  w_idx [N];
`endif
    logic                  w_vld;
    logic                  w_lst;

    if (l == 0) begin : g_src
      for (genvar k = 0; k < N; k++) begin : g_ln
        assign w_val[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef SW_MAX_ARGMAX_EN
        localparam logic [LEVELS-1:0] LN = LEVELS'(k);
        assign w_idx[k] = {r_beat, LN};
`endif
      end
      assign w_vld = w_in_vld;
      assign w_lst = in_last;
    end else begin : g_op
      logic [DATA_WIDTH-1:0] w_nv [N];
`ifdef SW_MAX_ARGMAX_EN
      logic [IDX_WIDTH-1:0]  w_ni [N];
`endif
      for (genvar k = 0; k < N; k++) begin : g_nd
        sw_max_node #(
          .DW(DATA_WIDTH)
`ifdef SW_MAX_ARGMAX_EN
          , .IW(IDX_WIDTH)
`endif
        ) u_node (
          .i_a_val(g_lv[l-1].w_val[2*k]),
          .i_b_val(g_lv[l-1].w_val[2*k+1]),
`ifdef SW_MAX_ARGMAX_EN
          .i_a_idx(g_lv[l-1].w_idx[2*k]),
          .i_b_idx(g_lv[l-1].w_idx[2*k+1]),
          .o_idx  (w_ni[k]),
`endif
          .o_val  (w_nv[k])
        );
      end

      if ((l % PIPE_EVERY == 0) || (l == LEVELS)) begin : g_reg
        logic [DATA_WIDTH-1:0] r_val [N];
`ifdef SW_MAX_ARGMAX_EN
        logic [IDX_WIDTH-1:0]  r_idx [N];
`endif
        logic                  r_vld;
        logic                  r_lst;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_vld <= 1'b0;
            r_lst <= 1'b0;
            r_val <= '{default: '0};
`ifdef SW_MAX_ARGMAX_EN
            r_idx <= '{default: '0};
`endif
          end else begin
            r_vld <= g_lv[l-1].w_vld & ~flush;
            r_lst <= g_lv[l-1].w_lst;
            r_val <= w_nv;
`ifdef SW_MAX_ARGMAX_EN
            r_idx <= w_ni;
`endif
          end
        end

        assign w_val = r_val;
`ifdef SW_MAX_ARGMAX_EN
        assign w_idx = r_idx;
`endif
        assign w_vld = r_vld;
        assign w_lst = r_lst;
      end else begin : g_cmb
        assign w_val = w_nv;
`ifdef SW_MAX_ARGMAX_EN
        assign w_idx = w_ni;
`endif
        assign w_vld = g_lv[l-1].w_vld;
        assign w_lst = g_lv[l-1].w_lst;
      end
    end
  end

  assign w_t_vld = g_lv[LEVELS].w_vld & ~flush;
  assign w_t_lst = g_lv[LEVELS].w_lst;
  assign w_t_val = g_lv[LEVELS].w_val[0];
  assign w_load  = w_t_vld & w_t_lst;

  // accumulator sits on the a side so earlier beats win ties
  sw_max_node #(
    .DW(DATA_WIDTH)
`ifdef SW_MAX_ARGMAX_EN
    , .IW(IDX_WIDTH)
`endif
  ) u_merge (
    .i_a_val(r_acc_val),
    .i_b_val(w_t_val),
`ifdef SW_MAX_ARGMAX_EN
    .i_a_idx(r_acc_idx),
    .i_b_idx(w_t_idx),
    .o_idx  (w_m_idx),
`endif
    .o_val  (w_m_val)
  );

  assign w_res_val = (r_state == ACC_RUN) ? w_m_val : w_t_val;

`ifdef SW_MAX_ARGMAX_EN
  assign w_t_idx   = g_lv[LEVELS].w_idx[0];
  assign w_res_idx = (r_state == ACC_RUN) ? w_m_idx : w_t_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACC_IDLE;
      r_acc_val <= '0;
`ifdef SW_MAX_ARGMAX_EN
      r_acc_idx <= '0;
`endif
    end else if (flush) begin
      r_state   <= ACC_IDLE;
      r_acc_val <= '0;
`ifdef SW_MAX_ARGMAX_EN
      r_acc_idx <= '0;
`endif
    end else if (w_t_vld) begin
      unique case (r_state)
        ACC_IDLE: begin
          if (!w_t_lst) begin
            r_acc_val <= w_t_val;
`ifdef SW_MAX_ARGMAX_EN
            r_acc_idx <= w_t_idx;
`endif
            r_state   <= ACC_RUN;
          end
        end
        ACC_RUN: begin
          r_acc_val <= w_m_val;
`ifdef SW_MAX_ARGMAX_EN
          r_acc_idx <= w_m_idx;
`endif
          if (w_t_lst) r_state <= ACC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_max   <= '0;
`ifdef SW_MAX_ARGMAX_EN
      r_out_idx   <= '0;
`endif
      r_ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_max   <= w_res_val;
`ifdef SW_MAX_ARGMAX_EN
        r_out_idx   <= w_res_idx;
`endif
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if ((w_load && r_out_valid && !out_ready) || w_wrap_err)
        r_ovf <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_max   = r_out_max;
  assign ovf_err   = r_ovf;

`ifdef SW_MAX_ARGMAX_EN
  assign out_idx = r_out_idx;
`else
  assign out_idx = '0;
`endif

endmodule

// File: tb/tb_sw_max_argmax_tree.sv
// Scoreboard bench for sw_max_argmax_tree.
// Expectations follow SW_MAX_ARGMAX_EN when it is defined.
module tb_sw_max_argmax_tree;

  localparam int DW = 17;
  localparam int NI = 64;
  localparam int IW = 13;
  localparam int P  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [NI*DW-1:0] in_data = '0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [DW-1:0]    out_max;
  logic [IW-1:0]    out_idx;
  logic             ovf_err;

  always #5 clk = ~clk;

  sw_max_argmax_tree #(
    .DATA_WIDTH(DW),
    .NUM_IN    (NI),
    .IDX_WIDTH (IW),
    .PIPE_EVERY(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_idx  (out_idx),
    .ovf_err  (ovf_err)
  );

  typedef struct packed {
    logic [DW-1:0] mx;
    logic [IW-1:0] ix;
  } res_t;

  int            checks = 0;
  int            errors = 0;
  res_t          exp_q[$];
  logic [DW-1:0] lanes [NI];
  logic [DW-2:0] m_max;
  int            m_idx;
  int            m_beat;
  int            lat;

`ifdef SW_MAX_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_max  = '0;
    m_idx  = 0;
    m_beat = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill(input int modv, input int lane, input int val);
    for (int k = 0; k < NI; k++) lanes[k] = DW'(k % modv);
    if (lane >= 0) lanes[lane] = DW'(val);
  endtask

  task automatic send(input bit last, input bit push);
    res_t r;
    for (int k = 0; k < NI; k++) begin
      in_data[k*DW +: DW] = lanes[k];
      if (!lanes[k][DW-1] && lanes[k][DW-2:0] > m_max) begin
        m_max = lanes[k][DW-2:0];
        m_idx = (m_beat * NI + k) % (1 << IW);
      end
    end
    in_valid = 1'b1;
    in_last  = last;
    if (last) begin
      r.mx = {1'b0, m_max};
      r.ix = ARGMAX ? IW'(m_idx) : '0;
      if (push) exp_q.push_back(r);
      model_reset();
    end else begin
      m_beat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("result_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("res_max", 32'(out_max), 32'(r.mx));
        check("res_idx", 32'(out_idx), 32'(r.ix));
      end
    end
  end

  initial begin
    model_reset();
    cycles(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_max", 32'(out_max), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    fill(51, 5, 100);
    send(1, 1);
    idle();
    wait_out(lat);
    check("t1_latency", 32'(lat), 32'(P + 1));
    @(negedge clk);
    check("t1_drop", 32'(out_valid), 32'd0);
    cycles(1);

    fill(1, -1, 0);
    for (int k = 0; k < NI; k++) lanes[k] = 17'h1FFFD;
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(2);

    fill(1, 7, 42);
    lanes[9] = 17'd42;
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(2);

    fill(100, -1, 0);
    send(0, 1);
    fill(150, 3, 200);
    send(0, 1);
    fill(100, 0, 200);
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(3);

    fill(1, 2, 10);
    send(1, 1);
    fill(1, 6, 20);
    send(1, 1);
    idle();
    cycles(8);
    check("t4_ready_ovf", 32'(ovf_err), 32'd0);

    out_ready = 1'b0;
    fill(1, 4, 30);
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(1);
    fill(1, 10, 77);
    send(0, 1);
    idle();
    flush = 1'b1;
    model_reset();
    cycles(1);
    flush = 1'b0;
    cycles(6);
    check("t5_pend_valid", 32'(out_valid), 32'd1);
    check("t5_pend_max", 32'(out_max), 32'd30);
    out_ready = 1'b1;
    cycles(2);
    fill(1, 4, 9);
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(6);
    check("t5_ovf", 32'(ovf_err), 32'd0);

    out_ready = 1'b0;
    fill(1, 2, 10);
    send(1, 0);
    fill(1, 6, 20);
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(4);
    check("t4_bp_valid", 32'(out_valid), 32'd1);
    check("t4_bp_max", 32'(out_max), 32'd20);
    check("t4_bp_ovf", 32'(ovf_err), 32'd1);
    fill(1, 1, 55);
    send(0, 0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_max", 32'(out_max), 32'd0);
    check("arst_idx", 32'(out_idx), 32'd0);
    check("arst_ovf", 32'(ovf_err), 32'd0);
    exp_q.delete();
    model_reset();
    cycles(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(2);

    fill(51, 5, 100);
    send(1, 1);
    idle();
    wait_out(lat);
    check("t1b_latency", 32'(lat), 32'(P + 1));
    cycles(3);

    fill(1, -1, 0);
    for (int b = 0; b < 128; b++) send(0, 1);
    lanes[1] = 17'd5;
    send(1, 1);
    idle();
    wait_out(lat);
    cycles(3);
    check("t6_ovf", 32'(ovf_err), 32'(ARGMAX));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
